// File: rtl/gtx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gtx_ctrl_pkg: shared state encoding, output bundle and timing defaults (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package gtx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPLL_RST  = 3'd1,
    WAIT_LOCK = 3'd2,
    GT_RST    = 3'd3,
    WAIT_DONE = 3'd4,
    READY     = 3'd5,
    RETRY     = 3'd6,
    FAULT     = 3'd7
  } state_t;

  typedef struct packed {
    logic cpllreset;
    logic gttxreset;
    logic gtrxreset;
    logic txuserrdy;
    logic rxuserrdy;
    logic link_ready;
    logic fault;
  } ctrl_t;

  localparam int DEF_CPLLRESET_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT     = 4096;
  localparam int DEF_GTRESET_CYCLES   = 8;
  localparam int DEF_DONE_TIMEOUT     = 4096;
  localparam int DEF_MAX_RETRIES      = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output levels owned by each state; RETRY and IDLE drive everything low.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      CPLL_RST:  c.cpllreset = 1'b1;
      GT_RST: begin
        c.gttxreset = 1'b1;
        c.gtrxreset = 1'b1;
      end
      WAIT_DONE: begin
        c.txuserrdy = 1'b1;
        c.rxuserrdy = 1'b1;
      end
      READY: begin
        c.txuserrdy  = 1'b1;
        c.rxuserrdy  = 1'b1;
        c.link_ready = 1'b1;
      end
      FAULT: begin
        c.cpllreset = 1'b1;
        c.gttxreset = 1'b1;
        c.gtrxreset = 1'b1;
        c.fault     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff: two-flop synchronizer for a single asynchronous level (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

`default_nettype wire

// File: rtl/gtx_reset_seq.sv
// ---------------------------------------------------------------------------
// gtx_reset_seq: gt0 CPLL/GT reset and userrdy sequencer with bounded retry (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module gtx_reset_seq
  import gtx_ctrl_pkg::*;
#(
  parameter int CPLLRESET_CYCLES = DEF_CPLLRESET_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int GTRESET_CYCLES   = DEF_GTRESET_CYCLES,
  parameter int DONE_TIMEOUT     = DEF_DONE_TIMEOUT,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       gt0_cplllock_in,
  input  logic       gt0_txresetdone_in,
  input  logic       gt0_rxresetdone_in,
  output logic       gt0_cpllreset_out,
  output logic       gt0_gttxreset_out,
  output logic       gt0_gtrxreset_out,
  output logic       gt0_txuserrdy_out,
  output logic       gt0_rxuserrdy_out,
  output logic       LINK_READY,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT
);

  localparam int TIMER_SPAN = max_int(max_int(LOCK_TIMEOUT, DONE_TIMEOUT),
                                      max_int(CPLLRESET_CYCLES, GTRESET_CYCLES));
  localparam int TIMER_W    = (TIMER_SPAN > 1) ? $clog2(TIMER_SPAN) : 1;

  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         retry_cnt;
  logic [4:0]         retry_next;
  logic               lock_s;
  logic               txdone_s;
  logic               rxdone_s;
  logic               done_s;
  ctrl_t              ctrl_d;
  ctrl_t              ctrl_q;

  sync_2ff u_sync_lock   (.clk(CLK), .d(gt0_cplllock_in),    .q(lock_s));
  sync_2ff u_sync_txdone (.clk(CLK), .d(gt0_txresetdone_in), .q(txdone_s));
  sync_2ff u_sync_rxdone (.clk(CLK), .d(gt0_rxresetdone_in), .q(rxdone_s));

  assign done_s     = txdone_s & rxdone_s;
  assign retry_next = {1'b0, retry_cnt} + 5'd1;

  // Done beats timeout and lock beats timeout; lock loss in READY beats done loss.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (START) next_state = CPLL_RST;
      CPLL_RST:  if (timer == TIMER_W'(CPLLRESET_CYCLES - 1)) next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                                      next_state = GT_RST;
        else if (timer == TIMER_W'(LOCK_TIMEOUT - 1))    next_state = RETRY;
      end
      GT_RST:    if (timer == TIMER_W'(GTRESET_CYCLES - 1)) next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (done_s)                                      next_state = READY;
        else if (!lock_s)                                next_state = RETRY;
        else if (timer == TIMER_W'(DONE_TIMEOUT - 1))    next_state = RETRY;
      end
      READY: begin
        if (!lock_s)      next_state = RETRY;
        else if (!done_s) next_state = GT_RST;
      end
      RETRY: next_state = (retry_next == 5'(MAX_RETRIES)) ? gtx_ctrl_pkg::FAULT : CPLL_RST;
      gtx_ctrl_pkg::FAULT: next_state = gtx_ctrl_pkg::FAULT;
      default:   next_state = IDLE;
    endcase
    ctrl_d = decode_ctrl(next_state);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      timer     <= '0;
      retry_cnt <= '0;
      ctrl_q    <= '0;
    end else begin
      state  <= next_state;
      timer  <= (next_state != state) ? '0 : timer + TIMER_W'(1);
      ctrl_q <= ctrl_d;
      if (state == RETRY)
        retry_cnt <= (retry_cnt == 4'hF) ? 4'hF : retry_next[3:0];
      else if ((next_state == READY) && (state != READY))
        retry_cnt <= '0;
    end
  end

  assign gt0_cpllreset_out = ctrl_q.cpllreset;
  assign gt0_gttxreset_out = ctrl_q.gttxreset;
  assign gt0_gtrxreset_out = ctrl_q.gtrxreset;
  assign gt0_txuserrdy_out = ctrl_q.txuserrdy;
  assign gt0_rxuserrdy_out = ctrl_q.rxuserrdy;
  assign LINK_READY        = ctrl_q.link_ready;
  assign FAULT             = ctrl_q.fault;
  assign RETRY_CNT         = retry_cnt;

endmodule

`default_nettype wire

// File: doc/gtx_reset_seq.md
# gtx_reset_seq

Reset sequencer for a single GTX channel (gt0) on the ZC706 loopback design. It sits between the board-level start switch and the transceiver wrapper's reset and userrdy pins, and drives the CPLL reset, GTTXRESET/GTRXRESET and TX/RX USERRDY in the required order. It monitors lock and reset-done, applies timeouts with bounded retries, and reports link status.

## Interface
Parameters:
- CPLLRESET_CYCLES, 16: CLK cycles gt0_cpllreset_out is held high.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry.
- GTRESET_CYCLES, 8: cycles GTTXRESET/GTRXRESET are held high.
- DONE_TIMEOUT, 4096: cycles allowed in WAIT_DONE before a retry.
- MAX_RETRIES, 3: consecutive failed attempts before FAULT.

Ports:
- CLK  in  1  free-running system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  sequence request (switch level), sampled only in IDLE.
- gt0_cplllock_in  in  1  CPLL lock, asynchronous.
- gt0_txresetdone_in  in  1  TX reset done, asynchronous.
- gt0_rxresetdone_in  in  1  RX reset done, asynchronous.
- gt0_cpllreset_out  out  1  CPLL reset.
- gt0_gttxreset_out  out  1  GT TX reset.
- gt0_gtrxreset_out  out  1  GT RX reset.
- gt0_txuserrdy_out  out  1  TX user ready.
- gt0_rxuserrdy_out  out  1  RX user ready.
- LINK_READY  out  1  high only in READY.
- FAULT  out  1  high only in FAULT.
- RETRY_CNT  out  4  consecutive failed attempts, saturating.

## Operation
- The three async inputs pass through 2-FF synchronizers (lock_s, txdone_s, rxdone_s) before any use.
- One timer counter, cleared on every state entry. It is wide enough for max(LOCK_TIMEOUT, DONE_TIMEOUT).
- States:
  - IDLE: all outputs 0. START=1 → CPLL_RST.
  - CPLL_RST: cpllreset=1. Leave after CPLLRESET_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK: cpllreset=0. lock_s=1 → GT_RST. Timer = LOCK_TIMEOUT-1 with no lock → RETRY.
  - GT_RST: gttxreset=gtrxreset=1. Leave after GTRESET_CYCLES cycles → WAIT_DONE.
  - WAIT_DONE: txuserrdy=rxuserrdy=1. txdone_s & rxdone_s → READY. lock_s=0 → RETRY. Timer = DONE_TIMEOUT-1 → RETRY.
  - READY: userrdy=1, LINK_READY=1, RETRY_CNT cleared on entry. lock_s=0 → RETRY (lock loss takes priority). Otherwise either done_s=0 → GT_RST (no retry count).
  - RETRY: single cycle. If RETRY_CNT+1 = MAX_RETRIES → FAULT, else → CPLL_RST. RETRY_CNT increments in both cases.
  - FAULT: cpllreset=gttxreset=gtrxreset=1, userrdy=0, FAULT=1. Sticky; only RST leaves it.
- RETRY_CNT saturates at 15.
- START is ignored outside IDLE. START held high simply re-arms after RST.

## Timing
- All outputs are registered, decoded from the next-state value, so each output changes in the same cycle the state register changes.
- Reset values: every output 0, state IDLE, RETRY_CNT 0, timer 0.
- RST mid-sequence: on the next edge all outputs are 0 and the state is IDLE, regardless of state, including FAULT. RST has priority over START.
- START high at edge N → cpllreset high from edge N+1 through N+CPLLRESET_CYCLES.
- Input-to-action latency: an async input change acts on the state 3 edges after it (2 synchronizer edges + 1 state register edge).
- Same cycle lock_s=1 and timer expiry in WAIT_LOCK: lock wins.
- Same cycle done and timeout in WAIT_DONE: done wins.

## Structure
- Shared package gtx_ctrl_pkg holds the state enum (IDLE, CPLL_RST, WAIT_LOCK, GT_RST, WAIT_DONE, READY, RETRY, FAULT) and the default timing constants.
- One sub-module, sync_2ff, is instantiated three times for the async inputs.
- The FSM, timer and retry counter live in gtx_reset_seq.

## Test plan
Tests use CPLLRESET_CYCLES=16, LOCK_TIMEOUT=64, GTRESET_CYCLES=8, DONE_TIMEOUT=64, MAX_RETRIES=3.
- Nominal: START at edge 0; lock at edge 30; both resetdone 20 cycles after GT reset falls → cpllreset high for edges 1–16; GT resets high for exactly 8 cycles starting 3 edges after lock; LINK_READY=1 3 edges after resetdone; RETRY_CNT=0.
- Lock never asserts → three attempts of 16+64 cycles each, then FAULT=1, RETRY_CNT=3, all resets high, userrdy 0.
- Lock dropped in READY → LINK_READY=0 and userrdy=0 3 edges later; cpllreset high 16 cycles; RETRY_CNT=1; relock then resetdone → READY and RETRY_CNT=0.
- Only txresetdone rises in WAIT_DONE → RETRY after 64 cycles, cpllreset reasserted, RETRY_CNT=1.
- rxresetdone dropped in READY with lock stable → GT_RST for 8 cycles, cpllreset stays 0, RETRY_CNT unchanged.
- RST pulsed in GT_RST and in FAULT → all outputs 0 on the next edge; START held during RST has no effect; START after RST release restarts at CPLL_RST.
